// File: rtl/hsid_pkg.sv
// rtl/hsid_pkg.sv - shared widths, constants and FSM state type for the HSpecID-X control stage
package hsid_pkg;

    localparam int HSID_WORD_WIDTH        = 32;
    localparam int HSID_HSP_BANDS_WIDTH   = 8;
    localparam int HSID_HSP_LIBRARY_WIDTH = 8;

    localparam logic [HSID_WORD_WIDTH-1:0] HSID_MSE_INIT_MIN = '1;
    localparam int HSID_ADDR_BYTES_PER_BAND = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } hsid_x_ctrl_state_t;

endpackage

// File: rtl/hsid_x_ctrl_if.sv
// rtl/hsid_x_ctrl_if.sv - job request / MSE result bus between hsid_x_ctrl and the MSE datapath
interface hsid_x_ctrl_if
    import hsid_pkg::*;
#(
    parameter int WORD_WIDTH        = HSID_WORD_WIDTH,
    parameter int HSP_BANDS_WIDTH   = HSID_HSP_BANDS_WIDTH,
    parameter int HSP_LIBRARY_WIDTH = HSID_HSP_LIBRARY_WIDTH
);

    logic                         job_valid;
    logic                         job_ready;
    logic [HSP_LIBRARY_WIDTH-1:0] job_ref;
    logic [WORD_WIDTH-1:0]        job_lib_addr;
    logic [WORD_WIDTH-1:0]        job_cap_addr;
    logic [HSP_BANDS_WIDTH-1:0]   job_bands;

    logic                         res_valid;
    logic [HSP_LIBRARY_WIDTH-1:0] res_ref;
    logic [WORD_WIDTH-1:0]        res_value;

    modport master (
        output job_valid, job_ref, job_lib_addr, job_cap_addr, job_bands,
        input  job_ready,
        input  res_valid, res_ref, res_value
    );

    modport slave (
        input  job_valid, job_ref, job_lib_addr, job_cap_addr, job_bands,
        output job_ready,
        output res_valid, res_ref, res_value
    );

endinterface

// File: rtl/hsid_mse_min_max.sv
// rtl/hsid_mse_min_max.sv - running minimum/maximum MSE tracker with library reference capture
module hsid_mse_min_max
    import hsid_pkg::*;
#(
    parameter int WORD_WIDTH = HSID_WORD_WIDTH,
    parameter int REF_WIDTH  = HSID_HSP_LIBRARY_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  init,
    input  logic                  update,
    input  logic [WORD_WIDTH-1:0] value,
    input  logic [REF_WIDTH-1:0]  ref_idx,
    output logic [WORD_WIDTH-1:0] min_value,
    output logic [REF_WIDTH-1:0]  min_ref,
    output logic [WORD_WIDTH-1:0] max_value,
    output logic [REF_WIDTH-1:0]  max_ref
);

    localparam logic [WORD_WIDTH-1:0] INIT_MIN = {WORD_WIDTH{HSID_MSE_INIT_MIN[0]}};

    // Strict compares: results arrive in index order, so an equal value never displaces the earlier ref.
    always_ff @(posedge clk) begin
        if (rst || init) begin
            min_value <= INIT_MIN;
            min_ref   <= '0;
            max_value <= '0;
            max_ref   <= '0;
        end else if (update) begin
            if (value < min_value) begin
                min_value <= value;
                min_ref   <= ref_idx;
            end
            if (value > max_value) begin
                max_value <= value;
                max_ref   <= ref_idx;
            end
        end
    end

endmodule

// File: rtl/hsid_x_ctrl.sv
// rtl/hsid_x_ctrl.sv - sequences one MSE job per library pixel and collects in-order results
module hsid_x_ctrl
    import hsid_pkg::*;
#(
    parameter int WORD_WIDTH        = HSID_WORD_WIDTH,
    parameter int HSP_BANDS_WIDTH   = HSID_HSP_BANDS_WIDTH,
    parameter int HSP_LIBRARY_WIDTH = HSID_HSP_LIBRARY_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         clear,
    input  logic [HSP_LIBRARY_WIDTH-1:0] library_size,
    input  logic [HSP_BANDS_WIDTH-1:0]   pixel_bands,
    input  logic [WORD_WIDTH-1:0]        captured_pixel_addr,
    input  logic [WORD_WIDTH-1:0]        library_pixel_addr,
    output logic                         idle,
    output logic                         ready,
    output logic                         done,
    output logic                         error,
    output logic                         cancelled,
    output logic                         interruption,
    output logic [HSP_LIBRARY_WIDTH-1:0] mse_min_ref,
    output logic [HSP_LIBRARY_WIDTH-1:0] mse_max_ref,
    output logic [WORD_WIDTH-1:0]        mse_min_value,
    output logic [WORD_WIDTH-1:0]        mse_max_value,
    hsid_x_ctrl_if.master                dp
);

    localparam int CW = HSP_LIBRARY_WIDTH + 1;

    hsid_x_ctrl_state_t state_q, state_d;

    logic [CW-1:0]                issue_cnt_q, rcv_cnt_q, outstanding;
    logic [HSP_LIBRARY_WIDTH-1:0] lib_size_q;
    logic [HSP_BANDS_WIDTH-1:0]   bands_q;
    logic [WORD_WIDTH-1:0]        cap_addr_q, lib_addr_q, stride_q;
    logic                         done_q, error_q, cancelled_q, irq_q;

    logic cfg_ok, job_fire, ref_ok, last_res;
    logic mm_init, mm_update, evt_irq, set_err, set_cancel, set_done, clr_status, latch_cfg;

    assign cfg_ok      = (library_size != '0) && (pixel_bands != '0);
    assign job_fire    = dp.job_valid && dp.job_ready;
    assign ref_ok      = ({1'b0, dp.res_ref} == rcv_cnt_q);
    assign last_res    = ((rcv_cnt_q + CW'(1)) == {1'b0, lib_size_q});
    assign outstanding = issue_cnt_q - rcv_cnt_q;

    always_comb begin
        state_d    = state_q;
        mm_init    = 1'b0;
        mm_update  = 1'b0;
        evt_irq    = 1'b0;
        set_err    = 1'b0;
        set_cancel = 1'b0;
        set_done   = 1'b0;
        clr_status = 1'b0;
        latch_cfg  = 1'b0;
        case (state_q)
            IDLE: begin
                if (clear) begin
                    clr_status = 1'b1;
                    mm_init    = 1'b1;
                end else if (start) begin
                    if (cfg_ok) begin
                        latch_cfg  = 1'b1;
                        clr_status = 1'b1;
                        mm_init    = 1'b1;
                        state_d    = RUN;
                    end else begin
                        set_err = 1'b1;
                        evt_irq = 1'b1;
                    end
                end
            end
            RUN: begin
                // Cancel takes priority over any result arriving in the same cycle.
                if (clear) begin
                    set_cancel = 1'b1;
                    evt_irq    = 1'b1;
                    state_d    = DRAIN;
                end else if (dp.res_valid) begin
                    if (!ref_ok) begin
                        set_err = 1'b1;
                        evt_irq = 1'b1;
                        state_d = DRAIN;
                    end else begin
                        mm_update = 1'b1;
                        if (last_res) begin
                            set_done = 1'b1;
                            evt_irq  = 1'b1;
                            state_d  = FINISH;
                        end
                    end
                end
            end
            DRAIN: begin
                if ((outstanding == '0) || (dp.res_valid && (outstanding == CW'(1)))) begin
                    state_d = IDLE;
                end
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            issue_cnt_q <= '0;
            rcv_cnt_q   <= '0;
            lib_size_q  <= '0;
            bands_q     <= '0;
            cap_addr_q  <= '0;
            lib_addr_q  <= '0;
            stride_q    <= '0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            cancelled_q <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            // Back-to-back events (e.g. two rejected starts) must not merge into a two-cycle strobe.
            irq_q   <= evt_irq && !irq_q;
            if (clr_status) begin
                done_q      <= 1'b0;
                error_q     <= 1'b0;
                cancelled_q <= 1'b0;
            end
            if (set_err)    error_q     <= 1'b1;
            if (set_cancel) cancelled_q <= 1'b1;
            if (set_done)   done_q      <= 1'b1;
            if (latch_cfg) begin
                lib_size_q  <= library_size;
                bands_q     <= pixel_bands;
                cap_addr_q  <= captured_pixel_addr;
                lib_addr_q  <= library_pixel_addr;
                stride_q    <= WORD_WIDTH'(pixel_bands) * WORD_WIDTH'(HSID_ADDR_BYTES_PER_BAND);
                issue_cnt_q <= '0;
                rcv_cnt_q   <= '0;
            end else begin
                if (job_fire) begin
                    issue_cnt_q <= issue_cnt_q + CW'(1);
                    lib_addr_q  <= lib_addr_q + stride_q;
                end
                if (dp.res_valid && ((state_q == RUN) || ((state_q == DRAIN) && (outstanding != '0)))) begin
                    rcv_cnt_q <= rcv_cnt_q + CW'(1);
                end
            end
        end
    end

    hsid_mse_min_max #(
        .WORD_WIDTH (WORD_WIDTH),
        .REF_WIDTH  (HSP_LIBRARY_WIDTH)
    ) u_min_max (
        .clk       (clk),
        .rst       (rst),
        .init      (mm_init),
        .update    (mm_update),
        .value     (dp.res_value),
        .ref_idx   (dp.res_ref),
        .min_value (mse_min_value),
        .min_ref   (mse_min_ref),
        .max_value (mse_max_value),
        .max_ref   (mse_max_ref)
    );

    assign idle         = (state_q == IDLE);
    assign ready        = (state_q == IDLE);
    assign done         = done_q;
    assign error        = error_q;
    assign cancelled    = cancelled_q;
    assign interruption = irq_q;

    assign dp.job_valid    = (state_q == RUN) && (issue_cnt_q < {1'b0, lib_size_q});
    assign dp.job_ref      = issue_cnt_q[HSP_LIBRARY_WIDTH-1:0];
    assign dp.job_lib_addr = lib_addr_q;
    assign dp.job_cap_addr = cap_addr_q;
    assign dp.job_bands    = bands_q;

endmodule
